// File: rtl/riot_bus_master.sv
// riot_bus_master
//   Initiator for the RIOT/PIA strobe bus (stb/we/adr/dat, fixed read latency,
//   no acknowledge). A host-side source hands over commands on a valid/ready
//   port. Each access becomes a single-cycle strobe. Read data comes back on a
//   valid/ready response port.
//
//   Optional feature macro: RIOT_POLL_EN
//     When it is defined, a read with cmd_poll=1 keeps re-reading the same
//     address until the masked data matches, or until POLL_MAX strobes have
//     been issued.
//     When it is undefined, every read issues exactly one strobe and rsp_tmo
//     is tied to 0.
//
//   Parameters
//     READ_LAT  cycles from the strobe cycle to the cycle with valid dat_i (1..7)
//     POLL_MAX  maximum number of strobes per poll command (1..255)
//     POLL_GAP  idle cycles between poll strobes (0..15)
//
//   Ports
//     clk_i, rst_i           clock, synchronous active-high reset
//     cmd_valid/cmd_ready    command handshake
//     cmd_we/adr/dat         access type, address and write data
//     cmd_poll/mask/match    read-until-match controls (RIOT_POLL_EN only)
//     rsp_valid/rsp_ready    response handshake (reads only)
//     rsp_dat, rsp_tmo       read data and poll-timeout flag
//     stb_o, we_o, adr_o,    bus outputs; stb_o is the only qualifier
//     dat_o
//     dat_i                  bus read data from the responder
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | cmd_ready high, waiting for a command
//   STROBE | stb_o high for this single cycle
//   WAIT   | counting down the read latency, then sampling dat_i
//   GAP    | idle spacing between poll strobes (RIOT_POLL_EN only)
//   RESP   | rsp_valid high, holding data until rsp_ready
module riot_bus_master #(
    parameter int READ_LAT = 1,
    parameter int POLL_MAX = 255,
    parameter int POLL_GAP = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_we,
    input  logic [6:0] cmd_adr,
    input  logic [7:0] cmd_dat,
    input  logic       cmd_poll,
    input  logic [7:0] cmd_mask,
    input  logic [7:0] cmd_match,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_dat,
    output logic       rsp_tmo,
    output logic       stb_o,
    output logic       we_o,
    output logic [6:0] adr_o,
    output logic [7:0] dat_o,
    input  logic [7:0] dat_i
);

    localparam logic [2:0] LP_READ_LAT = 3'(READ_LAT);
    localparam logic [7:0] LP_POLL_MAX = 8'(POLL_MAX);
    localparam logic [3:0] LP_POLL_GAP = 4'(POLL_GAP);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STROBE = 3'd1,
        S_WAIT   = 3'd2,
`ifdef RIOT_POLL_EN
        S_GAP    = 3'd3,
`endif
        S_RESP   = 3'd4
    } state_t;

    state_t     r_state;
    logic       r_cmd_ready;
    logic       r_stb;
    logic       r_we;
    logic [6:0] r_adr;
    logic [7:0] r_dat;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_dat;
    logic [2:0] r_lat_cnt;

    state_t     w_state_nxt;
    logic       w_cmd_ready_nxt;
    logic       w_stb_nxt;
    logic       w_we_nxt;
    logic [6:0] w_adr_nxt;
    logic [7:0] w_dat_nxt;
    logic       w_rsp_valid_nxt;
    logic [7:0] w_rsp_dat_nxt;
    logic [2:0] w_lat_cnt_nxt;

`ifdef RIOT_POLL_EN
    logic       r_poll;
    logic [7:0] r_mask;
    logic [7:0] r_match;
    logic [7:0] r_poll_cnt;
    logic [3:0] r_gap_cnt;
    logic       r_tmo;

    logic       w_poll_nxt;
    logic [7:0] w_mask_nxt;
    logic [7:0] w_match_nxt;
    logic [7:0] w_poll_cnt_nxt;
    logic [3:0] w_gap_cnt_nxt;
    logic       w_tmo_nxt;
    logic       w_hit;

    // r_rsp_dat holds the most recent sample during the compare cycle.
    assign w_hit = ((r_rsp_dat & r_mask) == (r_match & r_mask));
`else
    logic w_unused_poll;
    assign w_unused_poll = ^{cmd_poll, cmd_mask, cmd_match, LP_POLL_MAX, LP_POLL_GAP};
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_ready_nxt = 1'b0;
        w_stb_nxt       = 1'b0;
        w_we_nxt        = r_we;
        w_adr_nxt       = r_adr;
        w_dat_nxt       = r_dat;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_dat_nxt   = r_rsp_dat;
        w_lat_cnt_nxt   = r_lat_cnt;
`ifdef RIOT_POLL_EN
        w_poll_nxt      = r_poll;
        w_mask_nxt      = r_mask;
        w_match_nxt     = r_match;
        w_poll_cnt_nxt  = r_poll_cnt;
        w_gap_cnt_nxt   = r_gap_cnt;
        w_tmo_nxt       = r_tmo;
`endif

        case (r_state)
            S_IDLE: begin
                w_cmd_ready_nxt = 1'b1;
                // r_cmd_ready stays low in the first cycle out of reset, so
                // nothing is accepted until it has been visible to the host.
                if (cmd_valid && r_cmd_ready) begin
                    w_state_nxt     = S_STROBE;
                    w_cmd_ready_nxt = 1'b0;
                    w_stb_nxt       = 1'b1;
                    w_we_nxt        = cmd_we;
                    w_adr_nxt       = cmd_adr;
                    w_dat_nxt       = cmd_dat;
`ifdef RIOT_POLL_EN
                    // A write that also requests a poll is issued as a plain write.
                    w_poll_nxt      = cmd_poll & ~cmd_we;
                    w_mask_nxt      = cmd_mask;
                    w_match_nxt     = cmd_match;
                    w_poll_cnt_nxt  = 8'd0;
                    w_tmo_nxt       = 1'b0;
`endif
                end
            end

            S_STROBE: begin
`ifdef RIOT_POLL_EN
                if (r_poll_cnt != 8'hFF) begin
                    w_poll_cnt_nxt = r_poll_cnt + 8'd1;
                end
`endif
                if (r_we) begin
                    w_state_nxt     = S_IDLE;
                    w_cmd_ready_nxt = 1'b1;
                end else begin
                    w_state_nxt   = S_WAIT;
                    w_lat_cnt_nxt = LP_READ_LAT;
                end
            end

            S_WAIT: begin
                if (r_lat_cnt != 3'd0) begin
                    w_lat_cnt_nxt = r_lat_cnt - 3'd1;
                end
                if (r_lat_cnt == 3'd1) begin
                    w_rsp_dat_nxt = dat_i;
`ifdef RIOT_POLL_EN
                    // Polls stay here one more cycle (lat_cnt==0) to compare
                    // against the registered sample.
                    if (!r_poll) begin
                        w_state_nxt     = S_RESP;
                        w_rsp_valid_nxt = 1'b1;
                    end
`else
                    w_state_nxt     = S_RESP;
                    w_rsp_valid_nxt = 1'b1;
`endif
                end
`ifdef RIOT_POLL_EN
                else if (r_lat_cnt == 3'd0) begin
                    if (w_hit) begin
                        w_state_nxt     = S_RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_tmo_nxt       = 1'b0;
                    end else if (r_poll_cnt >= LP_POLL_MAX) begin
                        w_state_nxt     = S_RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_tmo_nxt       = 1'b1;
                    end else if (LP_POLL_GAP == 4'd0) begin
                        w_state_nxt = S_STROBE;
                        w_stb_nxt   = 1'b1;
                    end else begin
                        w_state_nxt   = S_GAP;
                        w_gap_cnt_nxt = LP_POLL_GAP;
                    end
                end
`endif
            end

`ifdef RIOT_POLL_EN
            S_GAP: begin
                if (r_gap_cnt <= 4'd1) begin
                    w_state_nxt   = S_STROBE;
                    w_stb_nxt     = 1'b1;
                    w_gap_cnt_nxt = 4'd0;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 4'd1;
                end
            end
`endif

            S_RESP: begin
                w_rsp_valid_nxt = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt     = S_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                    w_cmd_ready_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= 7'd0;
            r_dat       <= 8'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= 8'd0;
            r_lat_cnt   <= 3'd0;
`ifdef RIOT_POLL_EN
            r_poll      <= 1'b0;
            r_mask      <= 8'd0;
            r_match     <= 8'd0;
            r_poll_cnt  <= 8'd0;
            r_gap_cnt   <= 4'd0;
            r_tmo       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_stb       <= w_stb_nxt;
            r_we        <= w_we_nxt;
            r_adr       <= w_adr_nxt;
            r_dat       <= w_dat_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_dat   <= w_rsp_dat_nxt;
            r_lat_cnt   <= w_lat_cnt_nxt;
`ifdef RIOT_POLL_EN
            r_poll      <= w_poll_nxt;
            r_mask      <= w_mask_nxt;
            r_match     <= w_match_nxt;
            r_poll_cnt  <= w_poll_cnt_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_tmo       <= w_tmo_nxt;
`endif
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign stb_o     = r_stb;
    assign we_o      = r_we;
    assign adr_o     = r_adr;
    assign dat_o     = r_dat;
    assign rsp_valid = r_rsp_valid;
    assign rsp_dat   = r_rsp_dat;
`ifdef RIOT_POLL_EN
    assign rsp_tmo   = r_tmo;
`else
    assign rsp_tmo   = 1'b0;
`endif

endmodule

// File: tb/tb_riot_bus_master.sv
// Testbench for riot_bus_master: directed sequence with a response scoreboard
// and a small register-file/INTIM responder model.
module tb_riot_bus_master;

    localparam int RL   = 1;
    localparam int PG   = 3;
    localparam int PMAX = 4;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_we;
    logic [6:0] cmd_adr;
    logic [7:0] cmd_dat;
    logic       cmd_poll;
    logic [7:0] cmd_mask;
    logic [7:0] cmd_match;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_dat;
    logic       rsp_tmo;
    logic       stb_o;
    logic       we_o;
    logic [6:0] adr_o;
    logic [7:0] dat_o;
    logic [7:0] dat_i;

    riot_bus_master #(
        .READ_LAT (RL),
        .POLL_MAX (PMAX),
        .POLL_GAP (PG)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_poll  (cmd_poll),
        .cmd_mask  (cmd_mask),
        .cmd_match (cmd_match),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_tmo   (rsp_tmo),
        .stb_o     (stb_o),
        .we_o      (we_o),
        .adr_o     (adr_o),
        .dat_o     (dat_o),
        .dat_i     (dat_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Responder: plain registers, except 0x04 which behaves as a down-counting
    // INTIM (a write loads it, each read returns it and then decrements).
    logic [7:0] mem [128];
    logic [7:0] intim = 8'd0;
    logic [7:0] pipe [RL];

    always @(posedge clk_i) begin
        if (stb_o && we_o) begin
            if (adr_o == 7'h04) intim <= dat_o;
            else                mem[adr_o] <= dat_o;
        end
        if (stb_o && !we_o) begin
            if (adr_o == 7'h04) begin
                pipe[0] <= intim;
                if (intim != 8'd0) intim <= intim - 8'd1;
            end else begin
                pipe[0] <= mem[adr_o];
            end
        end else begin
            pipe[0] <= 8'hC3;
        end
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign dat_i = pipe[RL-1];

    int stb_q[$];
    always @(negedge clk_i) if (stb_o) stb_q.push_back(cyc);

    logic [8:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic we, input logic [6:0] adr, input logic [7:0] dat,
                            input logic poll, input logic [7:0] mask, input logic [7:0] match,
                            output int acc);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (!cmd_ready) check("cmd_ready_wait", 32'(cmd_ready), 32'(1));
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_poll  = poll;
        cmd_mask  = mask;
        cmd_match = match;
        acc       = cyc;
        tick();
        cmd_valid = 1'b0;
        cmd_poll  = 1'b0;
    endtask

    task automatic do_write(input logic [6:0] adr, input logic [7:0] dat);
        int acc;
        send_cmd(1'b1, adr, dat, 1'b0, 8'h00, 8'h00, acc);
        tick();
    endtask

    task automatic wait_rsp(input int acc, input int lat, input int stall);
        int n;
        int s0;
        logic [8:0] e;
        n = 0;
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
        end
        if (!rsp_valid) begin
            check("rsp_valid_wait", 32'(rsp_valid), 32'(1));
        end else begin
            check("rsp_latency", 32'(cyc - acc), 32'(lat));
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'(exp_q.size()), 32'(1));
                e = 9'h000;
            end else begin
                e = exp_q.pop_front();
            end
            s0 = stb_q.size();
            for (int i = 0; i < stall; i++) begin
                check("stall_rsp_valid", 32'(rsp_valid), 32'(1));
                check("stall_rsp_dat", 32'(rsp_dat), 32'(e[7:0]));
                check("stall_cmd_ready", 32'(cmd_ready), 32'(0));
                tick();
            end
            check("stall_no_strobe", 32'(stb_q.size()), 32'(s0));
            check("rsp_dat", 32'(rsp_dat), 32'(e[7:0]));
            check("rsp_tmo", 32'(rsp_tmo), 32'(e[8]));
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            check("rsp_valid_clear", 32'(rsp_valid), 32'(0));
            check("cmd_ready_after_rsp", 32'(cmd_ready), 32'(1));
        end
    endtask

    task automatic do_read(input logic [6:0] adr, input logic [8:0] exp, input logic poll,
                           input logic [7:0] mask, input logic [7:0] match,
                           input int lat, input int stall);
        int acc;
        exp_q.push_back(exp);
        send_cmd(1'b0, adr, 8'h00, poll, mask, match, acc);
        wait_rsp(acc, lat, stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int n0;
        rst_i     = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = 7'd0;
        cmd_dat   = 8'd0;
        cmd_poll  = 1'b0;
        cmd_mask  = 8'd0;
        cmd_match = 8'd0;
        rsp_ready = 1'b0;
        tick();
        tick();
        tick();

        // Reset state
        check("rst_cmd_ready", 32'(cmd_ready), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_stb",       32'(stb_o),     32'(0));
        check("rst_we",        32'(we_o),      32'(0));
        check("rst_adr",       32'(adr_o),     32'(0));
        check("rst_dat",       32'(dat_o),     32'(0));
        check("rst_rsp_dat",   32'(rsp_dat),   32'(0));
        check("rst_rsp_tmo",   32'(rsp_tmo),   32'(0));
        rst_i = 1'b0;
        tick();
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'(1));

        // Single write, cycle by cycle
        n0 = stb_q.size();
        send_cmd(1'b1, 7'h16, 8'h40, 1'b0, 8'h00, 8'h00, acc);
        check("wr_stb",       32'(stb_o),     32'(1));
        check("wr_we",        32'(we_o),      32'(1));
        check("wr_adr",       32'(adr_o),     32'(7'h16));
        check("wr_dat",       32'(dat_o),     32'(8'h40));
        check("wr_cmd_ready", 32'(cmd_ready), 32'(0));
        tick();
        check("wr_stb_off",     32'(stb_o),     32'(0));
        check("wr_ready_back",  32'(cmd_ready), 32'(1));
        check("wr_no_rsp",      32'(rsp_valid), 32'(0));
        check("wr_adr_hold",    32'(adr_o),     32'(7'h16));
        check("wr_stb_count",   32'(stb_q.size() - n0), 32'(1));
        check("wr_stb_cycle",   32'(stb_q[n0]), 32'(acc + 1));

        // Stray rsp_ready while idle does nothing
        rsp_ready = 1'b1;
        tick();
        tick();
        rsp_ready = 1'b0;
        check("stray_rsp_valid", 32'(rsp_valid), 32'(0));
        check("stray_cmd_ready", 32'(cmd_ready), 32'(1));

        // Plain read, turnaround 2+READ_LAT
        do_write(7'h02, 8'hFE);
        do_read(7'h02, {1'b0, 8'hFE}, 1'b0, 8'h00, 8'h00, 2 + RL, 0);

        // Read with a 10-cycle response stall
        do_write(7'h05, 8'h5A);
        do_read(7'h05, {1'b0, 8'h5A}, 1'b0, 8'h00, 8'h00, 2 + RL, 10);

        // Write with poll also set is a plain write; top address passes unmodified
        n0 = stb_q.size();
        send_cmd(1'b1, 7'h7F, 8'h33, 1'b1, 8'hFF, 8'h00, acc);
        for (int i = 0; i < 6; i++) tick();
        check("wrpoll_no_rsp",    32'(rsp_valid), 32'(0));
        check("wrpoll_stb_count", 32'(stb_q.size() - n0), 32'(1));
        do_read(7'h7F, {1'b0, 8'h33}, 1'b0, 8'h00, 8'h00, 2 + RL, 0);

        // Reset during WAIT aborts the read
        n0 = stb_q.size();
        send_cmd(1'b0, 7'h02, 8'h00, 1'b0, 8'h00, 8'h00, acc);
        tick();
        rst_i = 1'b1;
        tick();
        check("abort_stb",       32'(stb_o),     32'(0));
        check("abort_rsp_valid", 32'(rsp_valid), 32'(0));
        check("abort_cmd_ready", 32'(cmd_ready), 32'(0));
        rst_i = 1'b0;
        tick();
        check("abort_ready_back", 32'(cmd_ready), 32'(1));
        check("abort_adr_reset",  32'(adr_o),     32'(0));
        for (int i = 0; i < 4; i++) tick();
        check("abort_no_late_rsp", 32'(rsp_valid), 32'(0));
        check("abort_stb_count",   32'(stb_q.size() - n0), 32'(1));
        do_read(7'h16, {1'b0, 8'h40}, 1'b0, 8'h00, 8'h00, 2 + RL, 0);

`ifdef RIOT_POLL_EN
        // Poll INTIM counting 3 -> 0: four strobes, matched on the last
        do_write(7'h04, 8'h03);
        n0 = stb_q.size();
        do_read(7'h04, {1'b0, 8'h00}, 1'b1, 8'hFF, 8'h00, 1 + 3 * (PG + RL + 2) + RL + 2, 0);
        check("poll_stb_count", 32'(stb_q.size() - n0), 32'(4));
        if (stb_q.size() - n0 == 4) begin
            for (int i = 0; i < 3; i++)
                check("poll_spacing", 32'(stb_q[n0 + i + 1] - stb_q[n0 + i]), 32'(PG + RL + 2));
        end

        // Poll that never matches: POLL_MAX strobes then timeout with last sample
        n0 = stb_q.size();
        do_read(7'h05, {1'b1, 8'h5A}, 1'b1, 8'h0F, 8'h00, 1 + (PMAX - 1) * (PG + RL + 2) + RL + 2, 0);
        check("tmo_stb_count", 32'(stb_q.size() - n0), 32'(PMAX));
`else
        // Without polling support a poll request is an ordinary single read
        n0 = stb_q.size();
        do_read(7'h05, {1'b0, 8'h5A}, 1'b1, 8'hFF, 8'h00, 2 + RL, 0);
        check("nopoll_stb_count", 32'(stb_q.size() - n0), 32'(1));
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
